// File: rtl/dual_port_sync_memory.sv
// rtl/dual_port_sync_memory.sv - data memory with separate write/read ports and reset-time clear
//
// Purpose:
//   Single-clock data memory for the MEM stage of the 8-bit pipeline.
//   Writes land at the clock edge. Reads are registered and take one cycle,
//   and each read result comes with a one-cycle Read_Valid strobe.
//   After reset the memory is cleared one word per cycle. Busy stays high
//   while that happens, and any write or read request is ignored during the clear.
//
// Ports:
//   CLK         clock, everything on posedge
//   RST         synchronous active-high reset, restarts the clear at word 0
//   Write_EN    write request
//   Write_Addr  write address (a write to an address >= Depth is dropped)
//   Write_D     write data
//   Read_EN     read request
//   Read_Addr   read address (a read of an address >= Depth returns 0)
//   Read_D      registered read data, holds when no read is done
//   Read_Valid  high for one cycle when Read_D was loaded by a read
//   Busy        high while the clear sequence runs
//
// Configuration:
//   MEM_RD_BYPASS_EN  when defined, a read and write to the same address
//                     in the same cycle return the new data (write-first).
//                     When undefined, the read returns the old contents
//                     (read-first).

module dual_port_sync_memory #(
  parameter int Width      = 8,
  parameter int Depth      = 256,
  parameter int Addr_Width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Write_EN,
  input  logic [Addr_Width-1:0] Write_Addr,
  input  logic [Width-1:0]      Write_D,
  input  logic                  Read_EN,
  input  logic [Addr_Width-1:0] Read_Addr,
  output logic [Width-1:0]      Read_D,
  output logic                  Read_Valid,
  output logic                  Busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // One extra bit so that Depth == 2**Addr_Width can still be represented.
  localparam logic [Addr_Width:0]   DEPTH_EXT = (Addr_Width + 1)'(Depth);
  localparam logic [Addr_Width-1:0] LAST_ADDR = Addr_Width'(Depth - 1);

  state_t                state_q, state_d;
  logic [Addr_Width-1:0] clr_ptr_q, clr_ptr_d;
  logic [Width-1:0]      read_d_q, read_d_d;
  logic                  read_valid_q, read_valid_d;

  logic [Width-1:0]      mem [Depth];

  logic                  mem_we;
  logic [Addr_Width-1:0] mem_waddr;
  logic [Width-1:0]      mem_wdata;
  logic                  wr_in_range;
  logic                  rd_in_range;

  assign wr_in_range = ({1'b0, Write_Addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, Read_Addr} < DEPTH_EXT);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      read_d_q     <= '0;
      read_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      read_d_q     <= read_d_d;
      read_valid_q <= read_valid_d;
    end
  end

  // The memory array has no reset of its own. The clear sequence zeroes it.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d   = ST_READY;
          clr_ptr_d = '0;
        end
      end
      default: begin
      end
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    mem_we       = 1'b0;
    mem_waddr    = Write_Addr;
    mem_wdata    = Write_D;
    read_d_d     = read_d_q;
    read_valid_d = 1'b0;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else begin
      mem_we = Write_EN && wr_in_range;
      if (Read_EN) begin
        read_valid_d = 1'b1;
        if (!rd_in_range) begin
          read_d_d = '0;
        end
`ifdef MEM_RD_BYPASS_EN
        else if (Write_EN && (Write_Addr == Read_Addr)) begin
          read_d_d = Write_D;
        end
`endif
        else begin
          read_d_d = mem[Read_Addr];
        end
      end
    end
  end

  assign Read_D     = read_d_q;
  assign Read_Valid = read_valid_q;
  assign Busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dual_port_sync_memory.sv
// tb/tb_dual_port_sync_memory.sv - self-checking bench for dual_port_sync_memory (Depth 256 and Depth 200 instances)

module tb_dual_port_sync_memory;

`ifdef MEM_RD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       we;
  logic [7:0] waddr;
  logic [7:0] wd;
  logic       re;
  logic [7:0] raddr;
  logic [7:0] rd_a, rd_b;
  logic       rv_a, rv_b;
  logic       busy_a, busy_b;

  dual_port_sync_memory #(.Width(8), .Depth(256), .Addr_Width(8)) dut_a (
    .CLK(clk), .RST(rst), .Write_EN(we), .Write_Addr(waddr), .Write_D(wd),
    .Read_EN(re), .Read_Addr(raddr), .Read_D(rd_a), .Read_Valid(rv_a), .Busy(busy_a)
  );

  dual_port_sync_memory #(.Width(8), .Depth(200), .Addr_Width(8)) dut_b (
    .CLK(clk), .RST(rst), .Write_EN(we), .Write_Addr(waddr), .Write_D(wd),
    .Read_EN(re), .Read_Addr(raddr), .Read_D(rd_b), .Read_Valid(rv_b), .Busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model. Index 0 is the Depth 256 instance, index 1 the Depth 200 instance.
  logic [7:0] m [2][256];
  int         clr_left [2];
  logic [7:0] e_rd [2];
  logic       e_rv [2];

  function automatic int depth_of(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the request rules to the inputs that are present at the coming edge.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int dep;
      dep = depth_of(d);
      if (rst) begin
        clr_left[d] = dep;
        e_rd[d]     = 8'h00;
        e_rv[d]     = 1'b0;
      end else if (clr_left[d] > 0) begin
        clr_left[d]--;
        e_rv[d] = 1'b0;
        if (clr_left[d] == 0) begin
          for (int i = 0; i < 256; i++) m[d][i] = 8'h00;
        end
      end else begin
        e_rv[d] = re;
        if (re) begin
          if (int'(raddr) >= dep) e_rd[d] = 8'h00;
          else if (BYPASS && we && (waddr == raddr)) e_rd[d] = wd;
          else e_rd[d] = m[d][raddr];
        end
        if (we && (int'(waddr) < dep)) m[d][waddr] = wd;
      end
    end
  endtask

  task automatic check_all();
    chk("busy_a", busy_a, clr_left[0] > 0);
    chk("busy_b", busy_b, clr_left[1] > 0);
    chk("rv_a", rv_a, e_rv[0]);
    chk("rv_b", rv_b, e_rv[1]);
    chk("rd_a", rd_a, e_rd[0]);
    chk("rd_b", rd_b, e_rd[1]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; waddr = 8'h00; wd = 8'h00; raddr = 8'h00;
  endtask

  // Pulses reset and counts the cycles Busy stays high on the Depth 256 instance.
  // Reads are requested throughout the clear and must be ignored.
  task automatic reset_and_count(input string name);
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk({name, "_busy_at_rst"}, busy_a, 1);
    n = 0;
    while (busy_a && n < 400) begin
      re    = 1'b1;
      raddr = 8'($urandom);
      step();
      chk({name, "_rv_during_clear"}, rv_a, 0);
      n++;
    end
    re = 1'b0;
    chk({name, "_busy_cycles"}, n, 256);
  endtask

  task automatic read_one(input logic [7:0] a, input logic [7:0] exp, input string name);
    idle_inputs();
    re = 1'b1; raddr = a;
    step();
    chk({name, "_rv"}, rv_a, 1);
    chk({name, "_rd"}, rd_a, exp);
    re = 1'b0;
  endtask

  typedef struct {
    bit         we;
    logic [7:0] waddr;
    logic [7:0] wd;
    bit         re;
    logic [7:0] raddr;
    bit         exp_rv;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vt [23];

  initial begin
    for (int i = 0; i < 2; i++) begin
      clr_left[i] = 0; e_rd[i] = 8'h00; e_rv[i] = 1'b0;
    end
    rst = 1'b0;
    idle_inputs();

    // Directed vectors, checked against the Depth 256 instance.
    vt[0] = '{1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 8'hA5};
    vt[2] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5};
    vt[3] = '{1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 1'b0, 8'hA5};
    vt[4] = '{1'b1, 8'h20, 8'h22, 1'b1, 8'h20, 1'b1, BYPASS ? 8'h22 : 8'h11};
    vt[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 1'b1, 8'h22};
    for (int k = 0; k < 8; k++) begin
      vt[6 + k]  = '{1'b1, 8'(k), 8'(k + 1), 1'b0, 8'h00, 1'b0, 8'h22};
      vt[14 + k] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'(k), 1'b1, 8'(k + 1)};
    end
    vt[22] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h08};

    @(negedge clk);

    // Initial reset and full clear, then spot reads.
    reset_and_count("t1");
    read_one(8'h00, 8'h00, "t1_rd00");
    read_one(8'h7F, 8'h00, "t1_rd7f");
    read_one(8'hFF, 8'h00, "t1_rdff");

    // Reset in the middle of a clear restarts it and wipes earlier data.
    idle_inputs();
    we = 1'b1; waddr = 8'h33; wd = 8'h5A;
    step();
    read_one(8'h33, 8'h5A, "t4_pre");
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("t4_busy_mid", busy_a, 1);
    reset_and_count("t4");
    read_one(8'h33, 8'h00, "t4_post");

    // Table: latency, collision and streaming.
    for (int i = 0; i < 23; i++) begin
      we = vt[i].we; waddr = vt[i].waddr; wd = vt[i].wd;
      re = vt[i].re; raddr = vt[i].raddr;
      step();
      chk($sformatf("vec%0d_rv", i), rv_a, vt[i].exp_rv);
      chk($sformatf("vec%0d_rd", i), rd_a, vt[i].exp_rd);
    end

    // Out-of-range on the Depth 200 instance.
    idle_inputs();
    we = 1'b1; waddr = 8'hC8; wd = 8'hFF;
    step();
    idle_inputs();
    re = 1'b1; raddr = 8'hC8;
    step();
    chk("t5_rv_b", rv_b, 1);
    chk("t5_rd_b", rd_b, 8'h00);
    chk("t5_rd_a", rd_a, 8'hFF);
    for (int a = 0; a < 200; a++) begin
      raddr = 8'(a);
      step();
    end
    raddr = 8'h05;
    step();
    chk("t5_rd_b_05", rd_b, 8'h06);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      we  = $urandom_range(0, 1) != 0;
      re  = $urandom_range(0, 1) != 0;
      wd  = 8'($urandom);
      if ($urandom_range(0, 1) != 0) begin
        waddr = 8'($urandom_range(0, 15));
        raddr = ($urandom_range(0, 3) == 0) ? waddr : 8'($urandom_range(0, 15));
      end else begin
        waddr = 8'($urandom);
        raddr = 8'($urandom);
      end
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
